// File: rtl/vcore_pkg.sv
// Shared types and widths for the exe -> writeback response path.
package vcore_pkg;

    localparam int VCORE_OPCODE_W = 6;
    localparam int VCORE_VRF_ID_W = 2;
    localparam int VCORE_VDP_W    = 32;

    // One completed vector operation on its way to VRF writeback.
    typedef struct packed {
        logic [VCORE_OPCODE_W-1:0] opcode;
        logic [4:0]                vdst0_addr;
        logic [VCORE_VRF_ID_W-1:0] vdst1_id;
        logic                      wr_en;
        logic [VCORE_VDP_W-1:0]    wdata;
    } vcore_exe_wb_rsp_t;

endpackage

// File: rtl/vcore_ppln_exe_wb_rsp_if.sv
// Completion (exe -> block) and response (block -> writeback) handshakes.
interface vcore_ppln_exe_wb_rsp_if;
    import vcore_pkg::*;

    logic              cpl_valid;
    logic              cpl_ready;
    vcore_exe_wb_rsp_t cpl_data;
    logic              rsp_valid;
    logic              rsp_ready;
    vcore_exe_wb_rsp_t rsp_data;

    // Environment side: drives completions, consumes responses.
    modport master (
        output cpl_valid, cpl_data, rsp_ready,
        input  cpl_ready, rsp_valid, rsp_data
    );

    // Response block side.
    modport slave (
        input  cpl_valid, cpl_data, rsp_ready,
        output cpl_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/vcore_exe_wb_fifo.sv
// In-order completion buffer: storage array, wrapping pointers, occupancy.
module vcore_exe_wb_fifo
    import vcore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  vcore_exe_wb_rsp_t wr_data,
    output vcore_exe_wb_rsp_t rd_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    vcore_exe_wb_rsp_t mem [DEPTH];

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every register see pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload write; at full with a simultaneous pop the slot being read is
    // overwritten only at the edge, after the head has been consumed.
    always_ff @(posedge clk) begin
        // NOTE: payload RAM is deliberately unreset; valid is tracked by count.
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/vcore_ppln_exe_wb_rsp.sv
// Exe -> writeback response buffer with issue-credit return to dispatch.
module vcore_ppln_exe_wb_rsp
    import vcore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_fire,
    output logic                         credit_avail,
    output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
    output logic                         err_credit,
    vcore_ppln_exe_wb_rsp_if.slave       wb
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic full;
    logic empty;
    logic push;
    logic pop;

    // No bypass: a fresh completion only becomes visible once stored.
    assign wb.cpl_ready = ~full | wb.rsp_ready;
    assign wb.rsp_valid = ~empty;
    assign push         = wb.cpl_valid & wb.cpl_ready;
    assign pop          = wb.rsp_valid & wb.rsp_ready;

    vcore_exe_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wb.cpl_data),
        .rd_data (wb.rsp_data),
        .full    (full),
        .empty   (empty)
    );

    // Credit counter: issue spends, pop returns; out-of-range moves saturate and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CNT_W'(DEPTH);
            err_credit <= 1'b0;
        end else begin
            case ({issue_fire, pop})
                2'b10: begin
                    if (credit_cnt == '0) err_credit <= 1'b1;
                    else                  credit_cnt <= credit_cnt - 1'b1;
                end
                2'b01: begin
                    if (credit_cnt == CNT_W'(DEPTH)) err_credit <= 1'b1;
                    else                             credit_cnt <= credit_cnt + 1'b1;
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    assign credit_avail = (credit_cnt != '0);

endmodule
